// File: rtl/mult_16_rr_sched.sv
// rtl/mult_16_rr_sched.sv - round-robin scheduler sharing one pipelined fp16 multiplier
module mult_16_rr_sched #(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 3,
    parameter int ID_W     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  hold_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*16-1:0] req_data_1_i,
    input  logic [NUM_REQ*16-1:0] req_data_2_i,
    output logic [15:0]           mult_data_1_o,
    output logic [15:0]           mult_data_2_o,
    input  logic [15:0]           mult_result_i,
    output logic                  rsp_valid_o,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic [15:0]           rsp_data_o,
    output logic                  busy_o
);

    logic [ID_W-1:0] rr_ptr;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] cand;
    logic [15:0]     win_a;
    logic [15:0]     win_b;

    logic            iss_v;
    logic [ID_W-1:0] iss_id;
    logic [MULT_LAT-1:0] tag_v;
    logic [ID_W-1:0] tag_id [MULT_LAT];

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
        return ID_W'((int'(base) + offset) % NUM_REQ);
    endfunction

    // Search begins just after the last winner, so the last winner has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = rr_index(rr_ptr, i);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
        if (hold_i || rst_i) begin
            grant_found = 1'b0;
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_found) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    assign win_a = req_data_1_i[{grant_id, 4'b0000} +: 16];
    assign win_b = req_data_2_i[{grant_id, 4'b0000} +: 16];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr        <= ID_W'(NUM_REQ - 1);
            mult_data_1_o <= '0;
            mult_data_2_o <= '0;
            iss_v         <= 1'b0;
            iss_id        <= '0;
            tag_v         <= '0;
            for (int i = 0; i < MULT_LAT; i++) begin
                tag_id[i] <= '0;
            end
            rsp_valid_o   <= 1'b0;
            rsp_id_o      <= '0;
            rsp_data_o    <= '0;
        end else begin
            if (grant_found) begin
                rr_ptr        <= grant_id;
                mult_data_1_o <= win_a;
                mult_data_2_o <= win_b;
                iss_v         <= 1'b1;
                iss_id        <= grant_id;
            end else begin
                mult_data_1_o <= '0;
                mult_data_2_o <= '0;
                iss_v         <= 1'b0;
            end

            // Tags travel alongside the multiplier stages; hold_i never touches them.
            tag_v[0]  <= iss_v;
            tag_id[0] <= iss_id;
            for (int i = 1; i < MULT_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end

            rsp_valid_o <= tag_v[MULT_LAT-1];
            if (tag_v[MULT_LAT-1]) begin
                rsp_data_o <= mult_result_i;
                rsp_id_o   <= tag_id[MULT_LAT-1];
            end
        end
    end

    assign busy_o = iss_v | (|tag_v);

endmodule
